multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the shared 32-bit datapath: register file, ALU, a single unified memory and a PC/IR pair.
- Replaces the single-cycle control unit with a state machine. Each instruction takes 3-5 cycles, so the ALU and memory are time-shared between fetch, address calculation and data access.
- Waits on a memory ready handshake.
- Counts retired instructions and halts on the all-ones instruction.

---
 rtl/multicycle_control_fsm_if.sv | 43 ++++
 rtl/multicycle_control_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the multi-cycle sequencer and the datapath.
interface multicycle_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    // Datapath status seen by the sequencer
    logic [31:0]      instr;
    logic             zero_flag;
    logic             mem_ready;

    // Datapath controls driven by the sequencer
    logic             pc_write;
    logic             pc_write_cond;
    logic [1:0]       pc_source;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;

    // Core status
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  instr, zero_flag, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
               mem_read, mem_write, mem_to_reg, reg_write, reg_dst,
               alu_src_a, alu_src_b, alu_op, halted, error, retired_count
    );

    modport slave (
        output instr, zero_flag, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
               mem_read, mem_write, mem_to_reg, reg_write, reg_dst,
               alu_src_a, alu_src_b, alu_op, halted, error, retired_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: time-shares ALU and unified memory across
// fetch, decode, execute, memory and write-back; counts retired instructions.
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    multicycle_control_fsm_if.master bus
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADDR = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_WB_MEM  = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC_R  = 4'd6;
    localparam logic [3:0] S_WB_R    = 4'd7;
    localparam logic [3:0] S_EXEC_I  = 4'd8;
    localparam logic [3:0] S_WB_I    = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_HALT    = 4'd12;

    logic [3:0]        state_q,   state_next;
    logic [WAIT_W-1:0] wait_q,    wait_next;
    logic [CNT_W-1:0]  retired_q, retired_next;
    logic              halted_q,  halted_next;
    logic              error_q,   error_next;
    logic              retire;
    logic              err_set;

    logic [5:0] opcode;
    logic       is_halt;

    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a;
    logic [1:0] pc_source, alu_src_b, alu_op;

    assign opcode  = bus.instr[31:26];
    assign is_halt = (bus.instr == 32'hFFFF_FFFF);

    // State, wait counter, retire counter and sticky status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
            halted_q  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_next;
            wait_q    <= wait_next;
            retired_q <= retired_next;
            halted_q  <= halted_next;
            error_q   <= error_next;
        end
    end

    // Next-state: sequencing, memory wait/timeout, retire and error detection
    always_comb begin
        state_next = state_q;
        wait_next  = '0;
        retire     = 1'b0;
        err_set    = 1'b0;
        case (state_q)
            S_FETCH, S_MEMRD, S_MEMWR: begin
                if (bus.mem_ready) begin
                    case (state_q)
                        S_FETCH: state_next = S_DECODE;
                        S_MEMRD: state_next = S_WB_MEM;
                        default: begin
                            state_next = S_FETCH;
                            retire     = 1'b1;
                        end
                    endcase
                end else if (wait_q == WAIT_TOP) begin
                    state_next = S_HALT;
                    err_set    = 1'b1;
                end else begin
                    wait_next = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW:             state_next = S_MEMADDR;
                        OP_RTYPE:                 state_next = S_EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
                        OP_BEQ:                   state_next = S_BRANCH;
                        OP_J:                     state_next = S_JUMP;
                        default: begin
                            state_next = S_HALT;
                            err_set    = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADDR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_EXEC_R:  state_next = S_WB_R;
            S_EXEC_I:  state_next = S_WB_I;
            S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:    state_next = S_HALT;
            default: begin
                state_next = S_HALT;
                err_set    = 1'b1;
            end
        endcase
        retired_next = retired_q + CNT_W'(retire);
        halted_next  = halted_q | (state_next == S_HALT);
        error_next   = error_q | err_set;
    end

    // Control decode from the state register; forced low while reset is held
    // so write enables drop the instant reset asserts
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'd0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                S_DECODE:  alu_src_b = 2'd3;
                S_MEMADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = 2'd3;
                end
                S_WB_I:    reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'd1;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.pc_source     = pc_source;
    assign bus.ir_write      = ir_write;
    assign bus.i_or_d        = i_or_d;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.reg_write     = reg_write;
    assign bus.reg_dst       = reg_dst;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.halted        = halted_q;
    assign bus.error         = error_q;
    assign bus.retired_count = retired_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: expected control words are
// queued per cycle by the driver and compared at the falling edge.
module tb_multicycle_control_fsm;
    localparam int unsigned CNT_W = 32;

    localparam int P_FETCH   = 0;
    localparam int P_DECODE  = 1;
    localparam int P_MEMADDR = 2;
    localparam int P_MEMRD   = 3;
    localparam int P_WB_MEM  = 4;
    localparam int P_MEMWR   = 5;
    localparam int P_EXEC_R  = 6;
    localparam int P_WB_R    = 7;
    localparam int P_EXEC_I  = 8;
    localparam int P_WB_I    = 9;
    localparam int P_BRANCH  = 10;
    localparam int P_JUMP    = 11;
    localparam int P_HALT    = 12;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        logic [17:0] ctrl;
        logic [31:0] retired;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl_retired;
    logic        mdl_error;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
    //  mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_op, halted, error}
    function automatic logic [17:0] obs_ctrl();
        return {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.ir_write,
                bus.i_or_d, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                bus.reg_write, bus.reg_dst, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.halted, bus.error};
    endfunction

    // Expected control word for one phase of an instruction
    function automatic logic [17:0] exp_ctrl(input int ph, input logic rdy);
        logic       pw, pwc, iw, iod, mr, mw, m2r, rw, rd, asa, hl;
        logic [1:0] ps, asb, aop;
        {pw, pwc, iw, iod, mr, mw, m2r, rw, rd, asa, hl} = '0;
        {ps, asb, aop} = '0;
        case (ph)
            P_FETCH:   begin mr = 1'b1; asb = 2'd1; iw = rdy; pw = rdy; end
            P_DECODE:  asb = 2'd3;
            P_MEMADDR: begin asa = 1'b1; asb = 2'd2; end
            P_MEMRD:   begin mr = 1'b1; iod = 1'b1; end
            P_WB_MEM:  begin rw = 1'b1; m2r = 1'b1; end
            P_MEMWR:   begin mw = 1'b1; iod = 1'b1; end
            P_EXEC_R:  begin asa = 1'b1; aop = 2'd2; end
            P_WB_R:    begin rw = 1'b1; rd = 1'b1; end
            P_EXEC_I:  begin asa = 1'b1; asb = 2'd2; aop = 2'd3; end
            P_WB_I:    rw = 1'b1;
            P_BRANCH:  begin asa = 1'b1; aop = 2'd1; pwc = 1'b1; ps = 2'd1; end
            P_JUMP:    begin pw = 1'b1; ps = 2'd2; end
            default:   hl = 1'b1;
        endcase
        return {pw, pwc, ps, iw, iod, mr, mw, m2r, rw, rd, asa, asb, aop, hl, mdl_error};
    endfunction

    // One clock cycle: drive mem_ready, queue the expectation, advance
    task automatic step(input string tag, input int ph, input logic rdy);
        exp_t e;
        bus.mem_ready = rdy;
        e.tag     = tag;
        e.ctrl    = exp_ctrl(ph, rdy);
        e.retired = mdl_retired;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Assert reset (checking outputs drop at once), release between edges
    task automatic do_reset(input string tag);
        rst = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check({tag, "/ctrl"}, 32'(obs_ctrl()), 32'(0));
        check({tag, "/retired"}, bus.retired_count, 32'(0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        mdl_retired = '0;
        mdl_error   = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [31:0] ins, input bit is_r, input int fw);
        bus.instr = ins;
        for (int i = 0; i < fw; i++) step({tag, "/fwait"}, P_FETCH, 1'b0);
        step({tag, "/fetch"},  P_FETCH, 1'b1);
        step({tag, "/decode"}, P_DECODE, rnd());
        step({tag, "/exec"},   is_r ? P_EXEC_R : P_EXEC_I, rnd());
        step({tag, "/wb"},     is_r ? P_WB_R : P_WB_I, rnd());
        mdl_retired++;
    endtask

    task automatic run_mem(input string tag, input logic [31:0] ins, input bit is_lw, input int waits);
        bus.instr = ins;
        step({tag, "/fetch"},   P_FETCH, 1'b1);
        step({tag, "/decode"},  P_DECODE, rnd());
        step({tag, "/memaddr"}, P_MEMADDR, rnd());
        for (int i = 0; i < waits; i++) step({tag, "/mwait"}, is_lw ? P_MEMRD : P_MEMWR, 1'b0);
        step({tag, "/mem"}, is_lw ? P_MEMRD : P_MEMWR, 1'b1);
        if (is_lw) step({tag, "/wb"}, P_WB_MEM, rnd());
        mdl_retired++;
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins, input logic zf, input int ph);
        bus.instr     = ins;
        bus.zero_flag = zf;
        step({tag, "/fetch"},  P_FETCH, 1'b1);
        step({tag, "/decode"}, P_DECODE, rnd());
        step({tag, "/exec"},   ph, rnd());
        mdl_retired++;
    endtask

    // Scoreboard compare at the falling edge
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            check({mon_e.tag, "/ctrl"}, 32'(obs_ctrl()), 32'(mon_e.ctrl));
            check({mon_e.tag, "/retired"}, bus.retired_count, mon_e.retired);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        bus.instr     = 32'h0;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b0;
        mdl_retired   = '0;
        mdl_error     = 1'b0;

        do_reset("reset");
        run_alu("add", 32'h00221820, 1'b1, 0);
        run_mem("lw", 32'h8C220004, 1'b1, 3);
        run_mem("sw", 32'hAC220004, 1'b0, 0);
        run_mem("sw_wait", 32'hAC220008, 1'b0, 2);
        run_alu("addi", 32'h20220005, 1'b0, 0);
        run_alu("andi", 32'h3022000F, 1'b0, 0);
        run_alu("ori", 32'h34220010, 1'b0, 0);
        run_br("beq_taken", 32'h10220003, 1'b1, P_BRANCH);
        run_br("beq_not", 32'h10220003, 1'b0, P_BRANCH);
        run_br("j", 32'h08000010, 1'b0, P_JUMP);
        run_alu("add_fwait14", 32'h00221820, 1'b1, 14);
        run_mem("lw_wait14", 32'h8C220004, 1'b1, 14);

        // Halt instruction: no retire, no error, outputs frozen
        bus.instr = 32'hFFFFFFFF;
        step("halt/fetch", P_FETCH, 1'b1);
        step("halt/decode", P_DECODE, rnd());
        for (int i = 0; i < 20; i++) step("halt/hold", P_HALT, rnd());

        // Illegal opcode
        do_reset("reset_ill");
        bus.instr = 32'hFC000000;
        step("ill/fetch", P_FETCH, 1'b1);
        step("ill/decode", P_DECODE, 1'b1);
        mdl_error = 1'b1;
        for (int i = 0; i < 3; i++) step("ill/hold", P_HALT, 1'b1);

        // Fetch timeout
        do_reset("reset_fto");
        bus.instr = 32'h00221820;
        for (int i = 0; i < 15; i++) step("fto/fwait", P_FETCH, 1'b0);
        mdl_error = 1'b1;
        for (int i = 0; i < 3; i++) step("fto/hold", P_HALT, 1'b1);

        // Store timeout
        do_reset("reset_sto");
        bus.instr = 32'hAC220004;
        step("sto/fetch", P_FETCH, 1'b1);
        step("sto/decode", P_DECODE, 1'b0);
        step("sto/memaddr", P_MEMADDR, 1'b0);
        for (int i = 0; i < 15; i++) step("sto/mwait", P_MEMWR, 1'b0);
        mdl_error = 1'b1;
        for (int i = 0; i < 3; i++) step("sto/hold", P_HALT, 1'b1);

        // Reset in the middle of WB_R
        do_reset("reset_mid0");
        run_alu("mid_first", 32'h00221820, 1'b1, 0);
        bus.instr = 32'h00221820;
        step("mid/fetch", P_FETCH, 1'b1);
        step("mid/decode", P_DECODE, 1'b1);
        step("mid/exec", P_EXEC_R, 1'b1);
        #2;
        check("mid/reg_write_before", 32'(bus.reg_write), 32'(1));
        check("mid/retired_before", bus.retired_count, 32'(1));
        do_reset("mid_reset");
        run_alu("after_mid", 32'h00221820, 1'b1, 0);
        step("after_mid/next", P_FETCH, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
